// File: rtl/leap_wb_buffer_pkg.sv
// rtl/leap_wb_buffer_pkg.sv - Shared types for the leapt-writeback buffer
package leap_wb_buffer_pkg;

  typedef logic [31:0] rv32i_word;

  typedef struct packed {
    logic [4:0] rd;
    rv32i_word  data;
  } lwb_entry_t;

  typedef enum logic [1:0] {
    LWB_IDLE,
    LWB_CAPTURE,
    LWB_DRAIN
  } lwb_state_t;

endpackage

// File: rtl/lwb_fwd_search.sv
// rtl/lwb_fwd_search.sv - Youngest-match search over the live buffer entries
import leap_wb_buffer_pkg::*;

module lwb_fwd_search #(
  parameter int DEPTH = 4
) (
  input  lwb_entry_t [DEPTH-1:0]       entries,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [$clog2(DEPTH):0]       count,
  input  logic [4:0]                   addr,
  output logic                         hit,
  output rv32i_word                    data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest from head; a later match overrides, so the youngest wins
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && addr != 5'd0 && entries[idx].rd == addr) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/leap_wb_buffer.sv
// rtl/leap_wb_buffer.sv - In-order retire buffer for writebacks that leapt a cache miss (forwarding under LEAP_FWD_EN)
import leap_wb_buffer_pkg::*;

module leap_wb_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mem_done,
  input  logic [4:0]  fwd_rs1_addr,
  input  logic [4:0]  fwd_rs2_addr,
  output logic        fwd_rs1_hit,
  output logic        fwd_rs2_hit,
  output logic [31:0] fwd_rs1_data,
  output logic [31:0] fwd_rs2_data,
  output logic        full,
  output logic        drain_busy,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  lwb_state_t              state;
  lwb_entry_t [DEPTH-1:0]  entries;
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [CW-1:0]           count;

  logic wr_nz;
  logic push;
  logic pop;

  assign wr_nz = wb_valid && (wb_rd != 5'd0);
  assign push  = wr_nz && (state != LWB_DRAIN) && !full;
  assign pop   = (state == LWB_DRAIN);

  assign full       = (count == CW'(DEPTH));
  assign drain_busy = (state == LWB_DRAIN);
  assign rf_we      = (state == LWB_DRAIN);
  assign rf_rd      = rf_we ? entries[head].rd   : 5'd0;
  assign rf_data    = rf_we ? entries[head].data : 32'd0;

  // Entry storage needs no reset: count gates every read of it
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{rd: wb_rd, data: wb_data};
    end
  end

  // Pointers, occupancy, sticky overflow and the capture/drain FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LWB_IDLE;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (wr_nz && (full || state == LWB_DRAIN)) ovf <= 1'b1;
      case (state)
        // IDLE behaves like CAPTURE: a leaper arriving with mem_done drains at once
        LWB_IDLE, LWB_CAPTURE: begin
          if (mem_done && (count != '0 || push)) state <= LWB_DRAIN;
          else if (push)                         state <= LWB_CAPTURE;
          else if (mem_done)                     state <= LWB_IDLE;
        end
        LWB_DRAIN: begin
          if (count == CW'(1)) state <= LWB_IDLE;
        end
        default: state <= LWB_IDLE;
      endcase
    end
  end

`ifdef LEAP_FWD_EN
  lwb_fwd_search #(.DEPTH(DEPTH)) u_fwd_rs1 (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (fwd_rs1_addr),
    .hit     (fwd_rs1_hit),
    .data    (fwd_rs1_data)
  );

  lwb_fwd_search #(.DEPTH(DEPTH)) u_fwd_rs2 (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (fwd_rs2_addr),
    .hit     (fwd_rs2_hit),
    .data    (fwd_rs2_data)
  );
`else
  logic unused_fwd;
  assign unused_fwd   = ^{fwd_rs1_addr, fwd_rs2_addr};
  assign fwd_rs1_hit  = 1'b0;
  assign fwd_rs2_hit  = 1'b0;
  assign fwd_rs1_data = 32'd0;
  assign fwd_rs2_data = 32'd0;
`endif

endmodule

// File: tb/tb_leap_wb_buffer.sv
// tb/tb_leap_wb_buffer.sv - Scoreboard bench for leap_wb_buffer
module tb_leap_wb_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_done;
  logic [4:0]  fwd_rs1_addr;
  logic [4:0]  fwd_rs2_addr;
  logic        fwd_rs1_hit;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_rs1_data;
  logic [31:0] fwd_rs2_data;
  logic        full;
  logic        drain_busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        ovf;

  leap_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mem_done     (mem_done),
    .fwd_rs1_addr (fwd_rs1_addr),
    .fwd_rs2_addr (fwd_rs2_addr),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_data (fwd_rs2_data),
    .full         (full),
    .drain_busy   (drain_busy),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_data      (rf_data),
    .ovf          (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the buffer as a plain list, oldest first
  logic [4:0]  mb_rd[$];
  logic [31:0] mb_data[$];
  logic        m_drain = 1'b0;
  logic        m_ovf   = 1'b0;
  // Scoreboard of regfile writes still owed by the DUT
  logic [4:0]  exp_rd[$];
  logic [31:0] exp_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void mfwd(input logic [4:0] a, output logic h, output logic [31:0] v);
    h = 1'b0;
    v = 32'd0;
    if (a != 5'd0) begin
`ifdef LEAP_FWD_EN
      for (int i = 0; i < mb_rd.size(); i++) begin
        if (mb_rd[i] == a) begin
          h = 1'b1;
          v = mb_data[i];
        end
      end
`endif
    end
  endfunction

  // Monitor: every regfile write must be the next owed entry
  initial begin
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        if (exp_rd.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rf_unexpected actual=rd%0d/%h required=no write at %0t", rf_rd, rf_data, $time);
        end else begin
          chk("rf_rd", 32'(rf_rd), 32'(exp_rd.pop_front()));
          chk("rf_data", rf_data, exp_data.pop_front());
        end
      end
    end
  end

  task automatic cycle(input logic r, input logic wv, input logic [4:0] rd, input logic [31:0] d,
                       input logic md, input logic [4:0] a1, input logic [4:0] a2);
    logic        h;
    logic [31:0] v;
    logic        vnz;
    @(negedge clk);
    #2;
    rst = r; wb_valid = wv; wb_rd = rd; wb_data = d; mem_done = md;
    fwd_rs1_addr = a1; fwd_rs2_addr = a2;
    #1;
    chk("full", 32'(full), 32'(mb_rd.size() == DEPTH));
    chk("drain_busy", 32'(drain_busy), 32'(m_drain));
    chk("rf_we", 32'(rf_we), 32'(m_drain));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    mfwd(a1, h, v);
    chk("fwd1_hit", 32'(fwd_rs1_hit), 32'(h));
    chk("fwd1_data", fwd_rs1_data, v);
    mfwd(a2, h, v);
    chk("fwd2_hit", 32'(fwd_rs2_hit), 32'(h));
    chk("fwd2_data", fwd_rs2_data, v);
    vnz = wv && (rd != 5'd0);
    if (!r) begin
      mb_rd.delete(); mb_data.delete(); exp_rd.delete(); exp_data.delete();
      m_drain = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_drain) begin
      if (vnz) m_ovf = 1'b1;
      void'(mb_rd.pop_front());
      void'(mb_data.pop_front());
      if (mb_rd.size() == 0) m_drain = 1'b0;
    end else begin
      if (vnz && mb_rd.size() == DEPTH) m_ovf = 1'b1;
      else if (vnz) begin
        mb_rd.push_back(rd);
        mb_data.push_back(d);
      end
      if (md && mb_rd.size() > 0) begin
        for (int i = 0; i < mb_rd.size(); i++) begin
          exp_rd.push_back(mb_rd[i]);
          exp_data.push_back(mb_data[i]);
        end
        m_drain = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
  endtask

  initial begin
    rst = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0; mem_done = 1'b0;
    fwd_rs1_addr = '0; fwd_rs2_addr = '0;
    repeat (2) @(negedge clk);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    idle(1);

    // Two leapers then mem_done: two ordered writes
    cycle(1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 5'd5, 5'd6);
    cycle(1'b1, 1'b1, 5'd6, 32'h22, 1'b0, 5'd5, 5'd6);
    cycle(1'b1, 1'b0, 5'd0, 32'd0,  1'b1, 5'd5, 5'd6);
    idle(4);

    // Same rd twice: youngest forwarded, oldest written first
    cycle(1'b1, 1'b1, 5'd7, 32'hA, 1'b0, 5'd7, 5'd0);
    cycle(1'b1, 1'b1, 5'd7, 32'hB, 1'b0, 5'd7, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd8);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0);
    idle(4);

    // Fill to DEPTH, overflow attempt, then drain
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b1, 5'(i + 8), 32'(i * 3), 1'b0, 5'd9, 5'd12);
    cycle(1'b1, 1'b1, 5'd20, 32'h55, 1'b0, 5'd20, 5'd9);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd0);
    idle(DEPTH + 2);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

    // rd == 0 is discarded silently
    cycle(1'b1, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 5'd0);
    idle(2);

    // Push concurrent with mem_done in CAPTURE
    cycle(1'b1, 1'b1, 5'd1, 32'h100, 1'b0, 5'd3, 5'd1);
    cycle(1'b1, 1'b1, 5'd3, 32'h300, 1'b1, 5'd3, 5'd1);
    idle(4);

    // Reset during a three-entry drain
    cycle(1'b1, 1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 5'd0);
    cycle(1'b1, 1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 5'd0);
    cycle(1'b1, 1'b1, 5'd6, 32'h6, 1'b0, 5'd0, 5'd0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    cycle(1'b1, 1'b1, 5'd9, 32'h9, 1'b0, 5'd4, 5'd6);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 5'd6);
    idle(3);

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      cycle(1'b1 && ($urandom_range(0, 79) != 0),
            $urandom_range(0, 2) != 0,
            5'($urandom_range(0, 7)),
            $urandom,
            $urandom_range(0, 6) == 0,
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
    end
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    idle(DEPTH + 3);
    chk("scoreboard_empty", 32'(exp_rd.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/leap_wb_buffer.md
# leap_wb_buffer

Holds register-file results of instructions that leapt past a memory-access stage stalled on a data-cache miss, then retires them in program order after the stalled load/store completes. Sits beside the writeback stage: captures leapt writebacks during the miss, drains them one per cycle to the regfile write port after the miss, and forwards buffered values to younger leapt instructions. Preserves WAW ordering when a leapt instruction and the stalled load target the same rd.

## Interface
- DEPTH, 4: buffer entries (power of two, 2..8)
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- wb_valid  in  1  leapt instruction writeback this cycle
- wb_rd  in  5  its destination register
- wb_data  in  32  its result (rv32i_word)
- mem_done  in  1  stalled load/store completes; its own writeback happens this cycle on the normal path
- fwd_rs1_addr, fwd_rs2_addr  in  5 each  source registers of the instruction in EX
- fwd_rs1_hit, fwd_rs2_hit  out  1 each  buffered value exists for that source
- fwd_rs1_data, fwd_rs2_data  out  32 each  youngest matching buffered value
- full  out  1  count == DEPTH; upstream must block further leaps
- drain_busy  out  1  buffer owns regfile write port; pipeline stalls writeback
- rf_we  out  1  regfile write enable
- rf_rd  out  5  regfile write address
- rf_data  out  32  regfile write data
- ovf  out  1  sticky: push attempted while full or during DRAIN

## Operation
- Circular FIFO of {rd, data}; head/tail pointers $clog2(DEPTH) bits, wrap modulo DEPTH; count $clog2(DEPTH)+1 bits.
- Push = wb_valid && wb_rd != 0 && state != DRAIN && !full. wb_rd == 0 discarded silently, no state change.
- States: IDLE, CAPTURE, DRAIN.
- IDLE: count 0. Push -> CAPTURE. mem_done alone -> stay IDLE (miss with no leapers).
- CAPTURE: push as above. mem_done with count == 0 and no push -> IDLE. mem_done with count > 0 or push same cycle -> DRAIN (that cycle's push is included).
- DRAIN: rf_we = 1, rf_rd/rf_data = head entry, pop each cycle; when popping last entry -> IDLE. drain_busy = 1 throughout.
- Duplicate rd entries allowed; drain order oldest-first so youngest value lands last.
- Forwarding: search all valid entries, youngest match wins; address 0 never hits; hit outputs 0 when no match.
- ovf set on wb_valid && wb_rd != 0 while full or in DRAIN; entry dropped; cleared only by reset.

## Timing
- Reset: state IDLE, pointers/count 0, ovf 0; all outputs 0.
- Push at edge t visible in count, full, forwarding from cycle t+1.
- mem_done at cycle t -> first rf_we at t+1; N entries retire cycles t+1..t+N; drain_busy deasserts at t+N+1.
- full, drain_busy, rf_* are functions of registered state only (no input-to-output combinational path). Forwarding outputs are combinational from fwd_*_addr to buffer contents.
- Reset mid-DRAIN or mid-CAPTURE: all entries discarded, IDLE next cycle, no further rf_we.

## Configuration
- LEAP_FWD_EN defined: forwarding search and fwd_* outputs implemented as above.
- Not defined: fwd_*_hit and fwd_*_data tied 0; leapfrog must then treat any rd in buffer as a hazard (upstream responsibility); FIFO, FSM, drain unchanged.

## Structure
- Add to rv32i_types: lwb_entry_t (packed struct rd[4:0], data rv32i_word) and lwb_state_t enum {LWB_IDLE, LWB_CAPTURE, LWB_DRAIN}.
- One sub-module: lwb_fwd_search (DEPTH-parameterised youngest-match priority search over entries, head, count), instantiated twice, only under LEAP_FWD_EN.

## Test plan
- Reset, then push rd=5/0x11, rd=6/0x22, mem_done -> rf writes (5,0x11) then (6,0x22) on the next two cycles; drain_busy 2 cycles; IDLE after.
- Push rd=7/0xA then rd=7/0xB; fwd_rs1_addr=7 -> hit, data 0xB; drain writes 0xA then 0xB.
- DEPTH=4: push 4 entries -> full=1; 5th wb_valid -> dropped, ovf=1, count stays 4.
- wb_valid with rd=0 / data 0xFF -> no push, state stays IDLE, fwd on addr 0 -> no hit.
- Push rd=3 concurrent with mem_done in CAPTURE -> entry included, drains at t+1 after earlier entries in order.
- Assert rst=0 during DRAIN with 3 entries -> rf_we=0 next cycle, count 0, ovf 0.
